hilo_unit: RTL and testbench
============================

HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 SHALL provide clk  input  1  sole clock; all state changes on rising edge.
REQ-002 SHALL provide resetn  input  1  synchronous, active-low reset, sampled on rising clk edge.
REQ-003 SHALL provide EX_op_valid  input  1  EX-stage HI/LO instruction present this cycle.
REQ-004 SHALL provide EX_op  input  3  operation: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6-7 ignored.
REQ-005 SHALL provide EX_src_a  input  32  rs operand (dividend, multiplicand, mthi/mtlo data).
REQ-006 SHALL provide EX_src_b  input  32  rt operand (divisor, multiplier).
REQ-007 SHALL provide flush  input  1  exception/eret kill of in-flight HI/LO operation.
REQ-008 SHALL provide stall_out  output  1  hold IF/ID/EX; 1 while mult/div is unfinished.
REQ-009 SHALL provide WB_write_hilo  output  2  pending-commit enables, [1] HI, [0] LO; valid for one cycle.
REQ-010 SHALL provide WB_hilo  output  64  pending-commit data, [63:32] HI, [31:0] LO.
REQ-011 SHALL provide reg_hi, reg_lo  output  32 each  architectural HI/LO registers.

Function
REQ-012 SHALL implement states IDLE, MUL, DIV, DONE.
REQ-013 SHALL accept an op only in IDLE with EX_op_valid=1, flush=0, EX_op in 0-5; EX_op_valid in any other state is ignored (same held instruction).
REQ-014 SHALL assert stall_out combinationally in the accept cycle of mult/multu/div/divu and in every MUL or DIV cycle; stall_out=0 in IDLE otherwise and in DONE.
REQ-015 mult/multu: accept at T -> MUL at T+1, registered 64-bit product (signed or unsigned) -> DONE at T+2.
REQ-016 div/divu with EX_src_b!=0: accept at T -> DIV for T+1..T+32, one restoring quotient bit per cycle on operand magnitudes, 6-bit counter -> DONE at T+33.
REQ-017 Signed div: quotient negated iff operand signs differ; remainder sign = dividend sign; -2^31/-1 yields quotient 0x80000000, remainder 0.
REQ-018 div/divu with EX_src_b==0: accept at T -> DONE at T+1, result HI=EX_src_a, LO=0xFFFFFFFF.
REQ-019 In DONE: WB_write_hilo=2'b11, WB_hilo=result; reg_hi/reg_lo take WB_hilo at the end of that cycle; next state IDLE; no new op accepted in DONE.
REQ-020 mthi/mtlo: accept at T, no stall, state stays IDLE; at T+1 WB_write_hilo=2'b10 (mthi) or 2'b01 (mtlo), WB_hilo holds data in the selected half, other half 0; the register updates at the end of T+1.
REQ-021 A new op SHALL be acceptable at T+1 after mthi/mtlo; the mthi/mtlo commit and the new op's later commit never collide.
REQ-022 WB_write_hilo SHALL be 2'b00 in every cycle without a commit; WB_hilo holds its last value.
REQ-023 flush=1 in any cycle: state -> IDLE, counter cleared, no commit issued in that cycle or later for the killed op, stall_out=0 in that cycle, reg_hi/reg_lo unchanged.
REQ-024 Ops 6-7 and EX_op_valid=0 SHALL cause no state change.

Reset
REQ-025 resetn=0 at a rising edge SHALL set state IDLE, counter 0, reg_hi=reg_lo=0, WB_hilo=0, WB_write_hilo=0; stall_out=0 while resetn=0.
REQ-026 Reset SHALL take precedence over flush and abort any mult/div in progress without commit.

Verification
REQ-027 mult a=0xFFFFFFFD, b=5 -> stall_out=1 for 2 cycles, DONE: WB_hilo=0xFFFFFFFF_FFFFFFF1, WB_write_hilo=11; then reg_hi=0xFFFFFFFF, reg_lo=0xFFFFFFF1.
REQ-028 multu a=0xFFFFFFFF, b=2 -> reg_hi=0x00000001, reg_lo=0xFFFFFFFE; div a=0xFFFFFFF9, b=2 -> 33 stall cycles, reg_lo=0xFFFFFFFD, reg_hi=0xFFFFFFFF.
REQ-029 divu a=100, b=7 -> reg_lo=14, reg_hi=2; divu b=0, a=0x12345678 -> 1 stall cycle, reg_hi=0x12345678, reg_lo=0xFFFFFFFF.
REQ-030 mthi 0xAAAA5555 then mult 3*4 next cycle -> WB_write_hilo=10 at T+1, reg_hi=0xAAAA5555, then reg_hi=0, reg_lo=12 two cycles later.
REQ-031 flush at DIV cycle 10 -> stall_out=0 that cycle, no WB_write_hilo pulse ever, reg_hi/reg_lo unchanged; resetn=0 at DIV cycle 20 -> all outputs 0, no commit.

Source files
------------

// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO register unit for a MIPS-style pipeline.
// Executes mult/multu (one-cycle registered product), div/divu (restoring
// divider, one quotient bit per cycle) and mthi/mtlo. Results leave through a
// one-cycle write-back port and are committed to the HI/LO registers.
//
// Ports:
//   clk            sole clock, rising edge
//   resetn         synchronous active-low reset
//   EX_op_valid    HI/LO instruction present in EX this cycle
//   EX_op          0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo (6-7 ignored)
//   EX_src_a       rs operand (dividend / multiplicand / mthi-mtlo data)
//   EX_src_b       rt operand (divisor / multiplier)
//   flush          kills the in-flight HI/LO operation
//   stall_out      holds IF/ID/EX while a mult/div is unfinished
//   WB_write_hilo  commit enables, [1] HI, [0] LO, one cycle wide
//   WB_hilo        commit data, [63:32] HI, [31:0] LO
//   reg_hi/reg_lo  architectural HI/LO registers
module hilo_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic        EX_op_valid,
    input  logic [2:0]  EX_op,
    input  logic [31:0] EX_src_a,
    input  logic [31:0] EX_src_b,
    input  logic        flush,
    output logic        stall_out,
    output logic [1:0]  WB_write_hilo,
    output logic [63:0] WB_hilo,
    output logic [31:0] reg_hi,
    output logic [31:0] reg_lo
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] op_a;        // multiplicand, or dividend magnitude shifting into quotient
    logic [31:0] op_b;        // multiplier, or divisor magnitude
    logic [31:0] rem;         // partial remainder
    logic [5:0]  cnt;         // divide iteration counter
    logic        mul_signed;
    logic        q_neg;
    logic        r_neg;
    logic [1:0]  mt_pend;     // mthi/mtlo commit due next cycle

    logic        accept;
    logic        op_signed;
    logic        b_zero;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    logic [63:0] prod;
    logic [32:0] rem_sh;
    logic [32:0] diff;
    logic        ge;
    logic [31:0] rem_next;
    logic [31:0] quo_next;
    logic [31:0] quo_fin;
    logic [31:0] rem_fin;
    logic        last;

    assign accept    = (state == IDLE) && EX_op_valid && !flush && (EX_op <= 3'd5);
    assign op_signed = ~EX_op[0];
    assign b_zero    = (EX_src_b == 32'd0);
    assign a_mag     = (op_signed && EX_src_a[31]) ? (32'd0 - EX_src_a) : EX_src_a;
    assign b_mag     = (op_signed && EX_src_b[31]) ? (32'd0 - EX_src_b) : EX_src_b;

    // 64x64 multiply truncated to 64 bits gives the exact signed or unsigned
    // 32x32 product depending on how the operands are extended.
    assign prod = mul_signed ? ({{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b})
                             : ({32'd0, op_a} * {32'd0, op_b});

    // Restoring divide step: shift next dividend bit in, subtract if it fits.
    assign rem_sh   = {rem, op_a[31]};
    assign diff     = rem_sh - {1'b0, op_b};
    assign ge       = ~diff[32];
    assign rem_next = ge ? diff[31:0] : rem_sh[31:0];
    assign quo_next = {op_a[30:0], ge};
    assign quo_fin  = q_neg ? (32'd0 - quo_next) : quo_next;
    assign rem_fin  = r_neg ? (32'd0 - rem_next) : rem_next;
    assign last     = (cnt == 6'd31);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        stall_out     = 1'b0;
        WB_write_hilo = 2'b00;
        case (state)
            IDLE: begin
                WB_write_hilo = mt_pend;
                if (accept && !EX_op[2]) begin
                    stall_out = 1'b1;
                    if (EX_op[1]) begin
                        state_nxt = b_zero ? DONE : DIV;
                    end else begin
                        state_nxt = MUL;
                    end
                end
            end
            MUL: begin
                stall_out = 1'b1;
                state_nxt = DONE;
            end
            DIV: begin
                stall_out = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                WB_write_hilo = 2'b11;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt     = IDLE;
            stall_out     = 1'b0;
            WB_write_hilo = 2'b00;
        end
        if (!resetn) begin
            stall_out     = 1'b0;
            WB_write_hilo = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            op_a       <= '0;
            op_b       <= '0;
            rem        <= '0;
            cnt        <= '0;
            mul_signed <= 1'b0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
            mt_pend    <= '0;
            WB_hilo    <= '0;
            reg_hi     <= '0;
            reg_lo     <= '0;
        end else begin
            mt_pend <= '0;
            if (WB_write_hilo[1]) reg_hi <= WB_hilo[63:32];
            if (WB_write_hilo[0]) reg_lo <= WB_hilo[31:0];
            if (flush) begin
                cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            case (EX_op)
                                3'd0, 3'd1: begin
                                    op_a       <= EX_src_a;
                                    op_b       <= EX_src_b;
                                    mul_signed <= op_signed;
                                end
                                3'd2, 3'd3: begin
                                    if (b_zero) begin
                                        WB_hilo <= {EX_src_a, 32'hFFFF_FFFF};
                                    end else begin
                                        op_a  <= a_mag;
                                        op_b  <= b_mag;
                                        rem   <= '0;
                                        cnt   <= '0;
                                        q_neg <= op_signed && (EX_src_a[31] ^ EX_src_b[31]);
                                        r_neg <= op_signed && EX_src_a[31];
                                    end
                                end
                                3'd4: begin
                                    mt_pend <= 2'b10;
                                    WB_hilo <= {EX_src_a, 32'd0};
                                end
                                3'd5: begin
                                    mt_pend <= 2'b01;
                                    WB_hilo <= {32'd0, EX_src_a};
                                end
                                default: ;
                            endcase
                        end
                    end
                    MUL: begin
                        WB_hilo <= prod;
                    end
                    DIV: begin
                        op_a <= quo_next;
                        rem  <= rem_next;
                        cnt  <= cnt + 6'd1;
                        if (last) begin
                            WB_hilo <= {rem_fin, quo_fin};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: directed bench for hilo_unit. Expected commits are queued when
// an op is issued and checked by a monitor whenever WB_write_hilo pulses;
// any pulse with nothing queued is flagged.
module tb_hilo_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        EX_op_valid;
    logic [2:0]  EX_op;
    logic [31:0] EX_src_a;
    logic [31:0] EX_src_b;
    logic        flush;
    logic        stall_out;
    logic [1:0]  WB_write_hilo;
    logic [63:0] WB_hilo;
    logic [31:0] reg_hi;
    logic [31:0] reg_lo;

    typedef struct packed {
        logic [1:0]  wr;
        logic [63:0] data;
    } commit_t;

    commit_t sb[$];
    int total = 0;
    int bad   = 0;

    hilo_unit dut (
        .clk           (clk),
        .resetn        (resetn),
        .EX_op_valid   (EX_op_valid),
        .EX_op         (EX_op),
        .EX_src_a      (EX_src_a),
        .EX_src_b      (EX_src_b),
        .flush         (flush),
        .stall_out     (stall_out),
        .WB_write_hilo (WB_write_hilo),
        .WB_hilo       (WB_hilo),
        .reg_hi        (reg_hi),
        .reg_lo        (reg_lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        commit_t e;
        if (WB_write_hilo !== 2'b00) begin
            if (sb.size() == 0) begin
                chk("spurious_commit", {62'd0, WB_write_hilo}, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("commit_wr", {62'd0, WB_write_hilo}, {62'd0, e.wr});
                chk("commit_data", WB_hilo, e.data);
            end
        end
    end

    // Issue one op, count stall cycles from the accept cycle onward.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int exp_stall, input logic [1:0] wr, input logic [63:0] d,
                          input string tag);
        int n;
        n = 0;
        sb.push_back({wr, d});
        @(posedge clk); #1;
        EX_op_valid = 1'b1;
        EX_op       = op;
        EX_src_a    = a;
        EX_src_b    = b;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (stall_out !== 1'b1) break;
            n++;
            @(posedge clk); #1;
            EX_op_valid = 1'b0;
        end
        chk({tag, "_stall"}, 64'(n), 64'(exp_stall));
        @(posedge clk); #1;
        EX_op_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk); #1;
        end
        chk({tag, "_drained"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic chk_regs(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        chk({tag, "_reg_hi"}, 64'(reg_hi), 64'(hi));
        chk({tag, "_reg_lo"}, 64'(reg_lo), 64'(lo));
    endtask

    initial begin
        resetn      = 1'b0;
        EX_op_valid = 1'b0;
        EX_op       = 3'd0;
        EX_src_a    = 32'd0;
        EX_src_b    = 32'd0;
        flush       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", 64'(stall_out), 64'd0);
        chk("rst_wr", {62'd0, WB_write_hilo}, 64'd0);
        chk("rst_wb_hilo", WB_hilo, 64'd0);
        chk_regs("rst", 32'd0, 32'd0);
        resetn = 1'b1;

        run_op(3'd0, 32'hFFFF_FFFD, 32'd5, 2, 2'b11, 64'hFFFF_FFFF_FFFF_FFF1, "mult");
        wait_done("mult");
        chk_regs("mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        chk("hold_wr", {62'd0, WB_write_hilo}, 64'd0);
        chk("hold_wb_hilo", WB_hilo, 64'hFFFF_FFFF_FFFF_FFF1);

        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 2, 2'b11, 64'h0000_0001_FFFF_FFFE, "multu");
        wait_done("multu");
        chk_regs("multu", 32'h0000_0001, 32'hFFFF_FFFE);

        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 33, 2'b11, 64'hFFFF_FFFF_FFFF_FFFD, "div");
        wait_done("div");
        chk_regs("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        run_op(3'd3, 32'd100, 32'd7, 33, 2'b11, {32'd2, 32'd14}, "divu");
        wait_done("divu");
        chk_regs("divu", 32'd2, 32'd14);

        run_op(3'd3, 32'h1234_5678, 32'd0, 1, 2'b11, 64'h1234_5678_FFFF_FFFF, "divu0");
        wait_done("divu0");
        chk_regs("divu0", 32'h1234_5678, 32'hFFFF_FFFF);

        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 33, 2'b11, 64'h0000_0000_8000_0000, "divmin");
        wait_done("divmin");
        chk_regs("divmin", 32'd0, 32'h8000_0000);

        // -100 / 7 = -14 rem -2
        run_op(3'd2, 32'hFFFF_FF9C, 32'd7, 33, 2'b11, 64'hFFFF_FFFE_FFFF_FFF2, "divneg");
        wait_done("divneg");
        chk_regs("divneg", 32'hFFFF_FFFE, 32'hFFFF_FFF2);

        run_op(3'd5, 32'h1357_9BDF, 32'd0, 0, 2'b01, 64'h0000_0000_1357_9BDF, "mtlo");
        wait_done("mtlo");
        chk_regs("mtlo", 32'hFFFF_FFFE, 32'h1357_9BDF);

        // Reserved op: no stall, no commit.
        @(posedge clk); #1;
        EX_op_valid = 1'b1; EX_op = 3'd6; EX_src_a = 32'hDEAD_BEEF; EX_src_b = 32'd0;
        @(negedge clk);
        chk("op6_stall", 64'(stall_out), 64'd0);
        @(posedge clk); #1;
        EX_op_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk_regs("op6", 32'hFFFF_FFFE, 32'h1357_9BDF);

        // mthi immediately followed by mult.
        sb.push_back({2'b10, 64'hAAAA_5555_0000_0000});
        sb.push_back({2'b11, 64'd12});
        @(posedge clk); #1;
        EX_op_valid = 1'b1; EX_op = 3'd4; EX_src_a = 32'hAAAA_5555; EX_src_b = 32'd0;
        @(negedge clk);
        chk("mthi_stall", 64'(stall_out), 64'd0);
        @(posedge clk); #1;
        EX_op = 3'd0; EX_src_a = 32'd3; EX_src_b = 32'd4;
        @(negedge clk);
        chk("mthi_wr", {62'd0, WB_write_hilo}, 64'd2);
        chk("mult34_acc_stall", 64'(stall_out), 64'd1);
        @(posedge clk); #1;
        EX_op_valid = 1'b0;
        chk("mthi_reg_hi", 64'(reg_hi), 64'hAAAA_5555);
        wait_done("mult34");
        chk_regs("mult34", 32'd0, 32'd12);

        // Flush at DIV cycle 10: nothing may ever commit.
        @(posedge clk); #1;
        EX_op_valid = 1'b1; EX_op = 3'd3; EX_src_a = 32'd100; EX_src_b = 32'd7;
        @(posedge clk); #1;
        EX_op_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_stall", 64'(stall_out), 64'd0);
        chk("flush_wr", {62'd0, WB_write_hilo}, 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("post_flush_stall", 64'(stall_out), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        chk_regs("flush", 32'd0, 32'd12);

        // Reset at DIV cycle 20.
        @(posedge clk); #1;
        EX_op_valid = 1'b1; EX_op = 3'd2; EX_src_a = 32'd1000; EX_src_b = 32'd3;
        @(posedge clk); #1;
        EX_op_valid = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        resetn = 1'b0;
        @(negedge clk);
        chk("mid_rst_stall", 64'(stall_out), 64'd0);
        chk("mid_rst_wr", {62'd0, WB_write_hilo}, 64'd0);
        @(posedge clk); #1;
        chk("mid_rst_wb_hilo", WB_hilo, 64'd0);
        chk_regs("mid_rst", 32'd0, 32'd0);
        resetn = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("mid_rst_stall_after", 64'(stall_out), 64'd0);
        chk_regs("after_rst", 32'd0, 32'd0);

        run_op(3'd3, 32'd100, 32'd7, 33, 2'b11, {32'd2, 32'd14}, "divu_final");
        wait_done("divu_final");
        chk_regs("divu_final", 32'd2, 32'd14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
